// File: rtl/alu_pkg.sv
// alu_pkg: shared function codes, FSM state encoding and default widths for alu_exec.
package alu_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned DIGIT_W_DEF = 4;

    // alu_func codes; 101-111 are illegal and yield a zero result
    localparam logic [2:0] ALU_MOVE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_digit_slice.sv
// alu_digit_slice: combinational DIGIT_W-wide slice of the digit-serial ALU.
module alu_digit_slice
    import alu_pkg::*;
#(
    parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    input  logic [2:0]         func,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout
);

    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W-1:0] b_eff;

    // Subtraction reuses the adder with inverted B; the +1 arrives as the initial carry-in
    always_comb begin
        b_eff = (func == ALU_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
        digit = '0;
        cout  = 1'b0;
        case (func)
            ALU_MOVE: digit = b;
            ALU_ADD, ALU_SUB: begin
                digit = sum[DIGIT_W-1:0];
                cout  = sum[DIGIT_W];
            end
            ALU_AND:  digit = a & b;
            ALU_OR:   digit = a | b;
            default:  digit = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle digit-serial ALU with a registered one-cycle completion pulse.
// Optional: define ALU_FLAGS_EN to add registered alu_zero / alu_carry outputs.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_group,
    input  logic [2:0]        alu_func,
    input  logic              alu_in_sel,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_end,
`ifdef ALU_FLAGS_EN
    output logic              alu_zero,
    output logic              alu_carry,
`endif
    output logic              alu_busy
);

    localparam int unsigned N     = DATA_W / DIGIT_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    alu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]         func_q, func_d;
    logic               carry_q, carry_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               armed_q, armed_d;

    logic [DIGIT_W-1:0] a_dig, b_dig, slice_digit;
    logic               slice_cout;

    assign a_dig = a_q[int'(cnt_q)*DIGIT_W +: DIGIT_W];
    assign b_dig = b_q[int'(cnt_q)*DIGIT_W +: DIGIT_W];

    alu_digit_slice #(
        .DIGIT_W (DIGIT_W)
    ) u_slice (
        .a     (a_dig),
        .b     (b_dig),
        .cin   (carry_q),
        .func  (func_q),
        .digit (slice_digit),
        .cout  (slice_cout)
    );

    // Next-state: accept a start in IDLE, one digit per RUN edge, single DONE cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        func_d   = func_q;
        carry_d  = carry_q;
        result_d = result_q;
        armed_d  = armed_q;
        // en_group low re-arms so a level still high after DONE cannot restart
        if (!en_group) armed_d = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (en_group && armed_q) begin
                    a_d      = rs_data;
                    b_d      = alu_in_sel ? imm : rt_data;
                    func_d   = alu_func;
                    carry_d  = (alu_func == ALU_SUB);
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en_group) begin
                    // Abort: partial result is left as-is, no completion pulse
                    state_d = ST_IDLE;
                end else begin
                    result_d[int'(cnt_q)*DIGIT_W +: DIGIT_W] = slice_digit;
                    carry_d = slice_cout;
                    if (cnt_q == CNT_LAST) state_d = ST_DONE;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                armed_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= ALU_MOVE;
            carry_q  <= 1'b0;
            result_q <= '0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            func_q   <= func_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            armed_q  <= armed_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic zero_q, cflag_q;

    // Flags capture the final result and carry on the RUN->DONE edge only
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q  <= 1'b0;
            cflag_q <= 1'b0;
        end else if (state_q == ST_RUN && state_d == ST_DONE) begin
            zero_q  <= (result_d == '0);
            cflag_q <= (func_q == ALU_ADD || func_q == ALU_SUB) ? slice_cout : 1'b0;
        end
    end

    assign alu_zero  = zero_q;
    assign alu_carry = cflag_q;
`endif

    // Outputs decode registers only; nothing combinational from inputs
    assign alu_result = result_q;
    assign alu_end    = (state_q == ST_DONE);
    assign alu_busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed bench for alu_exec with a result scoreboard on alu_end.
module tb_alu_exec;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_group;
    logic [2:0] alu_func;
    logic       alu_in_sel;
    logic [7:0] rs_data, rt_data, imm;
    logic [7:0] alu_result;
    logic       alu_end, alu_busy;
`ifdef ALU_FLAGS_EN
    logic       alu_zero, alu_carry;
`endif

    int errors = 0;
    int checks = 0;
    int end_count = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_exec #(
        .DATA_W  (8),
        .DIGIT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_group   (en_group),
        .alu_func   (alu_func),
        .alu_in_sel (alu_in_sel),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm        (imm),
        .alu_result (alu_result),
        .alu_end    (alu_end),
`ifdef ALU_FLAGS_EN
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
`endif
        .alu_busy   (alu_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every alu_end pulse must match the oldest pushed expectation
    always @(negedge clk) begin
        if (alu_end) begin
            end_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_end", 32'(alu_end), 32'd0);
            end else begin
                check("sb_result", 32'(alu_result), 32'(exp_q.pop_front()));
            end
        end
    end

    // Full operation: start at T, check busy/end through T+3, then the write-back cycle
    task automatic run_op(input string tag, input logic [2:0] f, input logic sel,
                          input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] im,
                          input logic [7:0] exp, input logic exp_c);
        @(negedge clk);
        alu_func = f; alu_in_sel = sel; rs_data = rs; rt_data = rt; imm = im;
        en_group = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        // Operand changes after the start edge must be ignored
        rs_data = ~rs; rt_data = ~rt; imm = ~im; alu_func = ~f; alu_in_sel = ~sel;
        check({tag, "_busy1"}, 32'(alu_busy), 32'd1);
        check({tag, "_end1"}, 32'(alu_end), 32'd0);
        @(negedge clk);
        check({tag, "_busy2"}, 32'(alu_busy), 32'd1);
        check({tag, "_end2"}, 32'(alu_end), 32'd0);
        @(negedge clk);
        check({tag, "_end3"}, 32'(alu_end), 32'd1);
        check({tag, "_busy3"}, 32'(alu_busy), 32'd0);
`ifdef ALU_FLAGS_EN
        check({tag, "_zero"}, 32'(alu_zero), 32'(exp == 8'h00));
        check({tag, "_carry"}, 32'(alu_carry), 32'(exp_c));
`else
        if (exp_c === 1'bx) check({tag, "_carry_arg"}, 32'(exp_c), 32'd0);
`endif
        en_group = 1'b0;
        @(negedge clk);
        check({tag, "_wb_result"}, 32'(alu_result), 32'(exp));
        check({tag, "_wb_end"}, 32'(alu_end), 32'd0);
    endtask

    initial begin
        int ends_before;
        rst = 1'b1; en_group = 1'b0; alu_func = 3'b000; alu_in_sel = 1'b0;
        rs_data = 8'h00; rt_data = 8'h00; imm = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_result", 32'(alu_result), 32'd0);
        check("rst_end", 32'(alu_end), 32'd0);
        check("rst_busy", 32'(alu_busy), 32'd0);
        rst = 1'b0;

        run_op("add", ALU_ADD, 1'b0, 8'h3C, 8'h0F, 8'h77, 8'h4B, 1'b0);
        run_op("sub_imm", ALU_SUB, 1'b1, 8'h10, 8'h55, 8'h01, 8'h0F, 1'b1);
        run_op("sub_borrow", ALU_SUB, 1'b1, 8'h00, 8'h55, 8'h01, 8'hFF, 1'b0);
        run_op("and", ALU_AND, 1'b0, 8'hF0, 8'h3C, 8'h00, 8'h30, 1'b0);
        run_op("or", ALU_OR, 1'b0, 8'hF0, 8'h3C, 8'h00, 8'hFC, 1'b0);
        run_op("move", ALU_MOVE, 1'b0, 8'h12, 8'hA5, 8'h00, 8'hA5, 1'b0);
        run_op("illegal", 3'b111, 1'b0, 8'hF0, 8'h3C, 8'hFF, 8'h00, 1'b0);

        // Handshake: en_group held high past alu_end gives one pulse and no restart
        @(negedge clk);
        alu_func = ALU_ADD; alu_in_sel = 1'b0; rs_data = 8'h3C; rt_data = 8'h0F;
        en_group = 1'b1;
        exp_q.push_back(8'h4B);
        ends_before = end_count;
        repeat (3) @(negedge clk);
        check("hs_end", 32'(alu_end), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hs_hold_end", 32'(alu_end), 32'd0);
            check("hs_hold_busy", 32'(alu_busy), 32'd0);
            check("hs_hold_result", 32'(alu_result), 32'h4B);
        end
        check("hs_one_pulse", 32'(end_count - ends_before), 32'd1);
        en_group = 1'b0;
        @(negedge clk);
        rs_data = 8'h01; rt_data = 8'h02;
        en_group = 1'b1;
        exp_q.push_back(8'h03);
        @(negedge clk);
        check("hs_restart_busy", 32'(alu_busy), 32'd1);
        repeat (2) @(negedge clk);
        check("hs_restart_end", 32'(alu_end), 32'd1);
        en_group = 1'b0;
        @(negedge clk);

        // Abort: drop en_group in T+1
        @(negedge clk);
        alu_func = ALU_OR; rs_data = 8'hAA; rt_data = 8'h55;
        en_group = 1'b1;
        ends_before = end_count;
        @(negedge clk);
        check("abort_busy", 32'(alu_busy), 32'd1);
        en_group = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(alu_busy), 32'd0);
        check("abort_end", 32'(alu_end), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_pulse", 32'(end_count - ends_before), 32'd0);
        run_op("after_abort", ALU_ADD, 1'b1, 8'hF0, 8'h00, 8'h20, 8'h10, 1'b1);

        // Reset mid-RUN: rst high in T+2 (flags left at zero=0 carry=1 from previous op)
        @(negedge clk);
        alu_func = ALU_OR; rs_data = 8'h0F; rt_data = 8'hF0;
        en_group = 1'b1;
        ends_before = end_count;
        @(negedge clk);
        check("rstrun_busy", 32'(alu_busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstrun_result", 32'(alu_result), 32'd0);
        check("rstrun_end", 32'(alu_end), 32'd0);
        check("rstrun_busy0", 32'(alu_busy), 32'd0);
`ifdef ALU_FLAGS_EN
        check("rstrun_zero", 32'(alu_zero), 32'd0);
        check("rstrun_carry", 32'(alu_carry), 32'd0);
`endif
        rst = 1'b0; en_group = 1'b0;
        repeat (3) @(negedge clk);
        check("rstrun_no_pulse", 32'(end_count - ends_before), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
